// File: rtl/mem_bus_ctrl_pkg.sv
// puneh_mem_pkg: shared state type and constants for the PUNEH memory bus controller
package puneh_mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} mem_state_t;
  localparam logic [15:0] ERR_DATA = 16'hFFFF;
  localparam int TIMEOUT_DEF = 15;
endpackage

// File: rtl/mem_bus_ctrl_timeout_counter.sv
// mem_timeout_counter: counts unacknowledged wait cycles and flags the last allowed one
module mem_timeout_counter #(
  parameter int CNT_W = 4,
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [CNT_W-1:0] cnt;
  // clear outside WAIT, advance on every cycle without an acknowledge
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (en) cnt <= cnt + CNT_W'(1);
  assign tc = cnt == CNT_W'(TIMEOUT - 1);
endmodule

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: single-word req/ack memory access with bounded latency and error reporting
module mem_bus_ctrl
  import puneh_mem_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              readMEM,
  input  logic              writeMEM,
  input  logic [ADDR_W-1:0] addrBus,
  inout  wire  [DATA_W-1:0] dataBus,
  output logic              memReady,
  output logic              memErr,
  output logic [ADDR_W-1:0] ext_addr,
  output logic [DATA_W-1:0] ext_wdata,
  output logic              ext_we,
  output logic              ext_req,
  input  logic [DATA_W-1:0] ext_rdata,
  input  logic              ext_ack
);
  mem_state_t state;
  logic is_wr;
  logic tc;
  logic [DATA_W-1:0] rdata_q;
  mem_timeout_counter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) u_cnt (
    .clk(clk),
    .rst(rst),
    .clr(state != WAIT),
    .en(state == WAIT && !ext_ack),
    .tc(tc)
  );
  assign dataBus = (state == DONE && !is_wr) ? rdata_q : 'z;
  // command sampling, wait/ack/timeout handling and one-cycle completion pulses;
  // commands are ignored while an illegal-command pulse is showing so it stays one cycle
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      is_wr <= 1'b0;
      ext_req <= 1'b0;
      ext_we <= 1'b0;
      memReady <= 1'b0;
      memErr <= 1'b0;
      ext_addr <= '0;
      ext_wdata <= '0;
      rdata_q <= '0;
    end else begin
      memReady <= 1'b0;
      memErr <= 1'b0;
      if (state == IDLE && !memReady) begin
        if (readMEM && writeMEM) begin
          memReady <= 1'b1;
          memErr <= 1'b1;
        end else if (readMEM || writeMEM) begin
          ext_addr <= addrBus;
          ext_req <= 1'b1;
          ext_we <= writeMEM;
          is_wr <= writeMEM;
          if (writeMEM) ext_wdata <= dataBus;
          state <= WAIT;
        end
      end else if (state == WAIT) begin
        if (ext_ack || tc) begin
          ext_req <= 1'b0;
          ext_we <= 1'b0;
          memReady <= 1'b1;
          memErr <= !ext_ack;
          state <= DONE;
          if (!ext_ack) rdata_q <= DATA_W'(ERR_DATA);
          else if (!is_wr) rdata_q <= ext_rdata;
        end
      end else if (state == DONE) state <= IDLE;
    end
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: randomized scoreboard bench for mem_bus_ctrl against a transaction-level model
module tb_mem_bus_ctrl;
  localparam int TO = 15;
  logic clk = 0, rst = 1, readMEM = 0, writeMEM = 0, ext_ack = 0, drv = 0;
  logic [15:0] addrBus = 0, ext_rdata = 0, drv_data = 0;
  wire [15:0] dataBus;
  logic memReady, memErr, ext_we, ext_req;
  logic [15:0] ext_addr, ext_wdata;
  assign dataBus = drv ? drv_data : 'z;
  mem_bus_ctrl #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(TO), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .readMEM(readMEM), .writeMEM(writeMEM), .addrBus(addrBus),
    .dataBus(dataBus), .memReady(memReady), .memErr(memErr), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_we(ext_we), .ext_req(ext_req), .ext_rdata(ext_rdata),
    .ext_ack(ext_ack)
  );
  always #5 clk = ~clk;
  typedef struct {logic rd; logic err; logic [15:0] data; int reqs;} resp_t;
  typedef struct {logic [15:0] addr; logic we; logic [15:0] wdata;} req_t;
  resp_t rq[$];
  req_t qq[$];
  logic [15:0] mem[logic [15:0]];
  int tests = 0, fails = 0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    return mem.exists(a) ? mem[a] : a ^ 16'h5A3C;
  endfunction
  task automatic access(input int kind, input logic [15:0] a, input logic [15:0] d, input int waits);
    resp_t r;
    req_t q;
    bit done = 0;
    @(negedge clk);
    ext_ack = 0;
    readMEM = kind != 1;
    writeMEM = kind != 0;
    addrBus = a;
    drv = kind == 1;
    drv_data = d;
    r.rd = kind == 0;
    r.err = kind == 2 || waits >= TO;
    r.data = r.err ? 16'hFFFF : mem_rd(a);
    r.reqs = kind == 2 ? 0 : (waits >= TO ? TO : waits + 1);
    q.addr = a;
    q.we = kind == 1;
    q.wdata = d;
    if (kind != 2) qq.push_back(q);
    rq.push_back(r);
    @(negedge clk);
    drv = 0;
    for (int k = 0; k < TO + 4; k++) begin
      ext_ack = kind != 2 && k == waits;
      ext_rdata = kind == 0 ? mem_rd(a) : 16'($urandom);
      if (ext_ack && kind == 1 && waits < TO) mem[a] = d;
      if (memReady) begin
        done = 1;
        break;
      end
      @(negedge clk);
    end
    readMEM = 0;
    writeMEM = 0;
    if (!done) chk("completion_bound", 0, 1);
  endtask
  task automatic reset_mid(input logic [15:0] a);
    req_t q;
    @(negedge clk);
    ext_ack = 0;
    readMEM = 1;
    addrBus = a;
    q.addr = a;
    q.we = 0;
    q.wdata = 0;
    qq.push_back(q);
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    ext_ack = 1;
    ext_rdata = 16'hBEEF;
    @(negedge clk);
    chk("rst_mid_req", ext_req, 0);
    chk("rst_mid_ready", memReady, 0);
    chk("rst_mid_addr", ext_addr, 0);
    rst = 0;
    readMEM = 0;
    ext_ack = 0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_mid_no_ready", memReady, 0);
    end
  endtask
  logic req_prev = 0;
  int rc = 0;
  req_t cur;
  resp_t mr;
  always @(negedge clk) begin
    if (rst) begin
      req_prev = 0;
      rc = 0;
    end else begin
      if (ext_req && !req_prev) begin
        if (qq.size() == 0) chk("unexpected_req", 1, 0);
        else begin
          cur = qq.pop_front();
          chk("req_addr", ext_addr, cur.addr);
          chk("req_we", ext_we, cur.we);
          if (cur.we) chk("req_wdata", ext_wdata, cur.wdata);
        end
      end else if (ext_req) begin
        chk("hold_addr", ext_addr, cur.addr);
        chk("hold_we", ext_we, cur.we);
        if (cur.we) chk("hold_wdata", ext_wdata, cur.wdata);
      end
      if (ext_req) rc++;
      if (memReady) begin
        if (rq.size() == 0) chk("unexpected_ready", 1, 0);
        else begin
          mr = rq.pop_front();
          chk("resp_err", memErr, mr.err);
          chk("resp_req_cycles", rc, mr.reqs);
          if (mr.rd) chk("resp_data", dataBus, mr.data);
        end
        rc = 0;
      end else if (memErr) chk("err_without_ready", memErr, 0);
      req_prev = ext_req;
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1, "watchdog");
  end
  initial begin
    int kind, waits, sel;
    repeat (3) @(negedge clk);
    chk("reset_req", ext_req, 0);
    chk("reset_we", ext_we, 0);
    chk("reset_ready", memReady, 0);
    chk("reset_err", memErr, 0);
    chk("reset_addr", ext_addr, 0);
    chk("reset_wdata", ext_wdata, 0);
    rst = 0;
    mem[16'h0010] = 16'hA5A5;
    access(0, 16'h0010, 0, 0);
    access(1, 16'h0200, 16'h1234, 3);
    access(0, 16'h0200, 0, 1);
    access(0, 16'h0300, 0, TO + 8);
    access(2, 16'h0400, 0, 0);
    reset_mid(16'h0444);
    access(0, 16'h0010, 0, TO);
    access(0, 16'h0010, 0, 0);
    access(1, 16'h0020, 16'h9876, TO - 1);
    access(0, 16'h0020, 0, TO - 1);
    for (int i = 0; i < 250; i++) begin
      sel = $urandom_range(0, 9);
      kind = sel == 0 ? 2 : (sel < 5 ? 1 : 0);
      sel = $urandom_range(0, 9);
      waits = sel < 6 ? $urandom_range(0, 4) : (sel == 6 ? TO - 1 : (sel == 7 ? TO : (sel == 8 ? TO + 6 : $urandom_range(5, TO - 2))));
      access(kind, 16'($urandom_range(0, 7) << 4), 16'($urandom), waits);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    chk("resp_queue_empty", rq.size(), 0);
    chk("req_queue_empty", qq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
- Memory bus controller between the PUNEH datapath (addrBus/dataBus) and external synchronous memory with a req/ack handshake.
- Accepts single-word read/write commands from the controller FSM.
- Stalls the FSM until the access completes, then returns read data on the shared dataBus.
- Converts memory wait-states and a dead memory into a bounded-latency completion with an error flag.

Parameters:
- ADDR_W, 16, address width; matches addrBus.
- DATA_W, 16, data width; matches dataBus.
- TIMEOUT, 15, maximum WAIT cycles without ext_ack before abort; 1..2^CNT_W-1.
- CNT_W, 4, timeout counter width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- readMEM  in  1  read command from controller; sampled only in IDLE.
- writeMEM  in  1  write command from controller; sampled only in IDLE.
- addrBus  in  ADDR_W  address from datapath.
- dataBus  inout  DATA_W  shared bus; write data sampled from it, read data driven onto it.
- memReady  out  1  one-cycle completion pulse.
- memErr  out  1  one-cycle error pulse (timeout or illegal command).
- ext_addr  out  ADDR_W  registered memory address.
- ext_wdata  out  DATA_W  registered write data.
- ext_we  out  1  write enable; qualified by ext_req.
- ext_req  out  1  registered request.
- ext_rdata  in  DATA_W  memory read data; valid when ext_ack=1.
- ext_ack  in  1  single-cycle acknowledge; ignored unless ext_req=1.

Behaviour:
- States are IDLE, WAIT, DONE.
- Reset:
  - Next edge forces IDLE.
  - ext_req, ext_we, memReady, memErr go to 0; ext_addr, ext_wdata, rdata_q, cnt go to 0.
  - dataBus is released ('z).
  - Reset mid-access aborts it; a pending ext_ack is ignored.
- IDLE:
  - readMEM=1, writeMEM=0: latch addrBus into ext_addr; set ext_req=1, ext_we=0; cnt=0; go to WAIT.
  - writeMEM=1, readMEM=0: latch addrBus into ext_addr and dataBus into ext_wdata (datapath drives dataBus this cycle); set ext_req=1, ext_we=1; go to WAIT.
  - Both high: no access; memErr=1 and memReady=1 for one cycle; stay in IDLE.
  - ext_ack in IDLE is ignored.
- WAIT:
  - ext_req, ext_we, ext_addr and ext_wdata are held stable.
  - ext_ack=1: clear ext_req and ext_we; for a read, capture ext_rdata into rdata_q; go to DONE.
  - ext_ack=0: cnt increments. When cnt==TIMEOUT-1 without ack, clear ext_req, set rdata_q=ERR_DATA (all ones), go to DONE with an error flag.
  - Ack takes priority over timeout in the same cycle.
- DONE (exactly one cycle):
  - memReady=1; memErr=1 if the timeout flag is set.
  - For a read (including a timed-out read), dataBus is driven with rdata_q.
  - For a write, dataBus stays 'z.
  - Always return to IDLE.
- dataBus is driven only in read DONE; otherwise 'z. The datapath must not drive dataBus (seldataBus=0) in that cycle.
- Latency, from the command-sample edge:
  - ext_req is high from the next cycle.
  - With ack in the first WAIT cycle, DONE is 2 cycles after the command.
  - Worst case is TIMEOUT+1 cycles.
- Commands in WAIT/DONE are ignored. The controller holds the command until memReady, then drops it. A command still high in the IDLE cycle after DONE starts a new access.
- Back-to-back accesses: minimum 3 cycles per access.

Decomposition:
- Package puneh_mem_pkg holds:
  - enum mem_state_t {IDLE, WAIT, DONE}
  - localparam ERR_DATA = 16'hFFFF
  - default TIMEOUT value
- Sub-module mem_timeout_counter (clear, enable, terminal-count output) is natural.
- Everything else stays in mem_bus_ctrl.

Test Plan:
- Read with zero wait: readMEM at addrBus=16'h0010; ack next cycle with ext_rdata=16'hA5A5 -> ext_addr=16'h0010, memReady at cycle 2, dataBus=16'hA5A5 in that cycle only, memErr=0.
- Write with 3 wait-states: writeMEM, addrBus=16'h0200, dataBus=16'h1234 -> ext_we=1, ext_wdata=16'h1234 stable for 4 req cycles; memReady one cycle after ack; dataBus never driven.
- Timeout: read, ext_ack never asserted, TIMEOUT=15 -> ext_req high exactly 15 cycles; memReady=memErr=1 together; dataBus=16'hFFFF.
- Illegal command: readMEM=writeMEM=1 -> no ext_req; memErr=memReady=1 for one cycle; state stays IDLE.
- Reset mid-WAIT: rst in 2nd WAIT cycle, then ext_ack=1 -> ext_req=0 next edge; no memReady; ack ignored.
- Late ack plus held command: ack arrives one cycle after timeout -> ignored; readMEM still high after DONE starts exactly one new access.
